// File: rtl/vga_plotter.sv
`default_nettype none
// ============================================================================
// Module   : vga_plotter
// Purpose  : Frame-refresh engine: streams a 1bpp bitmap (or a background
//            fill) to the VGA wrapper pixel-write port.
// Revision : 1.0 - initial release
// ============================================================================
module vga_plotter #(
    parameter int         WIDTH     = 128,
    parameter int         HEIGHT    = 96,
    parameter int         ADDR_W    = 11,
    parameter logic [2:0] FG_COLOUR = 3'b111,
    parameter logic [2:0] BG_COLOUR = 3'b000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              clear,
    output logic              busy,
    output logic              done,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rdata,
    output logic [2:0]        colour,
    output logic [7:0]        x,
    output logic [6:0]        y,
    output logic              plot
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_WAIT  = 3'd2,
        S_PLOT  = 3'd3,
        S_CLR   = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    localparam logic [7:0]        X_LAST        = 8'(WIDTH - 1);
    localparam logic [7:0]        X_LAST_WORD   = 8'(WIDTH - 8);
    localparam logic [6:0]        Y_LAST        = 7'(HEIGHT - 1);
    localparam logic [ADDR_W-1:0] WORDS_PER_ROW = ADDR_W'(WIDTH / 8);

    state_t            state_q, state_d;
    logic [7:0]        px_q, px_d;
    logic [6:0]        py_q, py_d;
    logic [2:0]        bit_q, bit_d;
    logic [7:0]        shreg_q, shreg_d;

    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              mem_rd_q, mem_rd_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [2:0]        colour_q, colour_d;
    logic [7:0]        x_q, x_d;
    logic [6:0]        y_q, y_d;
    logic              plot_q, plot_d;

    always_comb begin
        state_d = state_q;
        px_d    = px_q;
        py_d    = py_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        case (state_q)
            S_IDLE: begin
                if (clear) begin
                    state_d = S_CLR;
                    px_d    = 8'd0;
                    py_d    = 7'd0;
                end else if (start) begin
                    state_d = S_FETCH;
                    px_d    = 8'd0;
                    py_d    = 7'd0;
                end
            end
            S_FETCH: state_d = S_WAIT;
            S_WAIT: begin
                shreg_d = mem_rdata;
                bit_d   = 3'd0;
                state_d = S_PLOT;
            end
            S_PLOT: begin
                if (bit_q == 3'd7) begin
                    bit_d = 3'd0;
                    if (px_q == X_LAST_WORD) begin
                        px_d = 8'd0;
                        if (py_q == Y_LAST) begin
                            state_d = S_DONE;
                        end else begin
                            py_d    = py_q + 7'd1;
                            state_d = S_FETCH;
                        end
                    end else begin
                        px_d    = px_q + 8'd8;
                        state_d = S_FETCH;
                    end
                end else begin
                    bit_d = bit_q + 3'd1;
                end
            end
            S_CLR: begin
                if (px_q == X_LAST) begin
                    px_d = 8'd0;
                    if (py_q == Y_LAST) begin
                        state_d = S_DONE;
                    end else begin
                        py_d = py_q + 7'd1;
                    end
                end else begin
                    px_d = px_q + 8'd1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are derived from the next-state values so that the registered
    // outputs line up with the state the engine is in during that cycle.
    always_comb begin
        busy_d     = (state_d == S_FETCH) || (state_d == S_WAIT) ||
                     (state_d == S_PLOT)  || (state_d == S_CLR);
        done_d     = (state_d == S_DONE);
        mem_rd_d   = (state_d == S_FETCH);
        plot_d     = (state_d == S_PLOT) || (state_d == S_CLR);
        mem_addr_d = mem_addr_q;
        x_d        = x_q;
        y_d        = y_q;
        colour_d   = colour_q;
        if (state_d == S_FETCH) begin
            mem_addr_d = ADDR_W'(py_d) * WORDS_PER_ROW + ADDR_W'(px_d[7:3]);
        end
        if (state_d == S_PLOT) begin
            x_d      = px_d + {5'd0, bit_d};
            y_d      = py_d;
            colour_d = shreg_d[3'd7 - bit_d] ? FG_COLOUR : BG_COLOUR;
        end else if (state_d == S_CLR) begin
            x_d      = px_d;
            y_d      = py_d;
            colour_d = BG_COLOUR;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_IDLE;
            px_q       <= 8'd0;
            py_q       <= 7'd0;
            bit_q      <= 3'd0;
            shreg_q    <= 8'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            mem_rd_q   <= 1'b0;
            mem_addr_q <= '0;
            colour_q   <= 3'd0;
            x_q        <= 8'd0;
            y_q        <= 7'd0;
            plot_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            px_q       <= px_d;
            py_q       <= py_d;
            bit_q      <= bit_d;
            shreg_q    <= shreg_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            mem_rd_q   <= mem_rd_d;
            mem_addr_q <= mem_addr_d;
            colour_q   <= colour_d;
            x_q        <= x_d;
            y_q        <= y_d;
            plot_q     <= plot_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign mem_rd   = mem_rd_q;
    assign mem_addr = mem_addr_q;
    assign colour   = colour_q;
    assign x        = x_q;
    assign y        = y_q;
    assign plot     = plot_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_plotter.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_plotter
// Purpose  : Self-checking bench for vga_plotter against a raster-order model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_plotter;

    localparam int W      = 128;
    localparam int H      = 96;
    localparam int WORDS  = W * H / 8;
    localparam int FRAME  = 10 * WORDS;
    localparam int CLRLEN = W * H;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        clear = 1'b0;
    logic        busy, done, mem_rd, plot;
    logic [10:0] mem_addr;
    logic [7:0]  mem_rdata = 8'd0;
    logic [2:0]  colour;
    logic [7:0]  x;
    logic [6:0]  y;

    logic [7:0]  mem [2048];

    int checks   = 0;
    int failures = 0;

    typedef struct { int cyc; int px; int py; int c; } plot_t;
    typedef struct { int cyc; int addr; } rd_t;
    plot_t pq[$];
    rd_t   rq[$];
    int    done_cyc, n_done, busy_cyc, busy_at_done;

    vga_plotter dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .clear     (clear),
        .busy      (busy),
        .done      (done),
        .mem_rd    (mem_rd),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .colour    (colour),
        .x         (x),
        .y         (y),
        .plot      (plot)
    );

    always #5 clock = ~clock;

    // Synchronous bitmap memory: data appears the cycle after the read strobe.
    always @(posedge clock) if (mem_rd) mem_rdata <= mem[mem_addr];

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    function automatic plot_t get_p(input int k);
        plot_t none = '{-1, -1, -1, -1};
        if (k >= 0 && k < pq.size()) return pq[k];
        return none;
    endfunction

    function automatic rd_t get_r(input int k);
        rd_t none = '{-1, -1};
        if (k >= 0 && k < rq.size()) return rq[k];
        return none;
    endfunction

    // Issue a command and log every plot/read/done seen until 3 cycles past done.
    // cyc=1 is the first cycle after the accepting clock edge.
    task automatic run_cmd(input bit s, input bit c, input bit poke);
        int cyc;
        pq.delete();
        rq.delete();
        done_cyc = -1; n_done = 0; busy_cyc = 0; busy_at_done = -1;
        start = s; clear = c;
        @(negedge clock);
        start = 1'b0; clear = 1'b0;
        cyc = 1;
        while (cyc < 20000) begin
            if (plot)   pq.push_back('{cyc, int'(x), int'(y), int'(colour)});
            if (mem_rd) rq.push_back('{cyc, int'(mem_addr)});
            if (busy)   busy_cyc++;
            if (done) begin
                n_done++;
                done_cyc     = cyc;
                busy_at_done = int'(busy);
            end
            if (done_cyc >= 0 && cyc >= done_cyc + 3) break;
            start = poke && (cyc % 1000 == 100);
            clear = poke && (cyc % 1000 == 600);
            @(negedge clock);
            cyc++;
        end
        start = 1'b0; clear = 1'b0;
    endtask

    task automatic check_refresh(input string tag);
        int perr = 0;
        int rerr = 0;
        for (int k = 0; k < W * H; k++) begin
            plot_t p  = get_p(k);
            int    ex = k % W;
            int    ey = k / W;
            int    ec = mem[ey * (W / 8) + ex / 8][7 - ex % 8] ? 7 : 0;
            int    et = 3 + (k / 8) * 10 + k % 8;
            if (p.px != ex || p.py != ey || p.c != ec || p.cyc != et) perr++;
        end
        for (int n = 0; n < WORDS; n++) begin
            rd_t r = get_r(n);
            if (r.addr != n || r.cyc != 1 + 10 * n) rerr++;
        end
        check({tag, "_plot_count"}, pq.size(), W * H);
        check({tag, "_rd_count"}, rq.size(), WORDS);
        check({tag, "_pixel_errs"}, perr, 0);
        check({tag, "_read_errs"}, rerr, 0);
        check({tag, "_done_cycle"}, done_cyc, FRAME + 1);
        check({tag, "_done_count"}, n_done, 1);
        check({tag, "_busy_cycles"}, busy_cyc, FRAME);
        check({tag, "_busy_at_done"}, busy_at_done, 0);
    endtask

    task automatic check_clear(input string tag);
        int perr = 0;
        for (int k = 0; k < CLRLEN; k++) begin
            plot_t p = get_p(k);
            if (p.px != k % W || p.py != k / W || p.c != 0 || p.cyc != 1 + k) perr++;
        end
        check({tag, "_plot_count"}, pq.size(), CLRLEN);
        check({tag, "_rd_count"}, rq.size(), 0);
        check({tag, "_pixel_errs"}, perr, 0);
        check({tag, "_done_cycle"}, done_cyc, CLRLEN + 1);
        check({tag, "_done_count"}, n_done, 1);
        check({tag, "_busy_cycles"}, busy_cyc, CLRLEN);
    endtask

    initial begin
        int    act;
        int    exp_c [8] = '{7, 0, 7, 0, 0, 0, 0, 0};
        plot_t p;

        for (int i = 0; i < 2048; i++) mem[i] = 8'd0;

        // Reset values
        repeat (3) @(negedge clock);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_mem_rd", mem_rd, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_colour", colour, 0);
        check("rst_x", x, 0);
        check("rst_y", y, 0);
        check("rst_plot", plot, 0);
        reset = 1'b0;
        @(negedge clock);

        // Reset mid-refresh aborts without a done pulse
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (400) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("midrst_plot", plot, 0);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_mem_rd", mem_rd, 0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        act = 0;
        repeat (200) begin
            @(negedge clock);
            act += int'(done) + int'(plot) + int'(mem_rd) + int'(busy);
        end
        check("post_rst_activity", act, 0);

        // Directed refresh: word 0 = 1010_0000, everything else 0
        mem[0] = 8'hA0;
        run_cmd(1'b1, 1'b0, 1'b0);
        check_refresh("frame1");
        check("f1_rd0_cycle", get_r(0).cyc, 1);
        check("f1_rd0_addr", get_r(0).addr, 0);
        act = 0;
        for (int i = 0; i < 8; i++) begin
            p = get_p(i);
            if (p.c != exp_c[i] || p.px != i || p.py != 0) act++;
        end
        check("f1_word0_pixels", act, 0);
        check("f1_rd1_addr", get_r(1).addr, 1);
        check("f1_rd16_addr", get_r(16).addr, 16);
        check("f1_row1_x", get_p(W).px, 0);
        check("f1_row1_y", get_p(W).py, 1);
        check("f1_last_x", get_p(W * H - 1).px, W - 1);
        check("f1_last_y", get_p(W * H - 1).py, H - 1);
        check("f1_last_cycle", get_p(W * H - 1).cyc, FRAME);
        check("f1_last_addr", get_r(WORDS - 1).addr, WORDS - 1);

        // Random bitmap, with start/clear pulses while busy
        for (int i = 0; i < WORDS; i++) mem[i] = 8'($urandom);
        run_cmd(1'b1, 1'b0, 1'b1);
        check_refresh("frame2");

        // Background fill
        run_cmd(1'b0, 1'b1, 1'b0);
        check_clear("clear");

        // Simultaneous start and clear: clear wins
        run_cmd(1'b1, 1'b1, 1'b0);
        check_clear("both");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
